// File: rtl/vc_fifo_buffer_pkg.sv
// Shared defaults and width helpers for the multi-channel input buffer.
// Imported by vc_fifo_lane and vc_fifo_buffer.
package vc_fifo_buffer_pkg;

  localparam int TAM_FLIT   = 16;
  localparam int TAM_BUFFER = 4;
  localparam int TAM_VC     = 2;

  function automatic int vc_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vc_fifo_lane.sv
// One virtual-channel circular FIFO: storage, pointers, flags, credit.
// Ports: push_i/pull_i/tail_i in; head/counter/flags/credit/err strobes out.
module vc_fifo_lane
  import vc_fifo_buffer_pkg::*;
#(
  parameter int WIDTH    = TAM_FLIT,
  parameter int DEPTH    = TAM_BUFFER,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int CW       = cnt_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pull_i,
  input  logic [WIDTH-1:0] tail_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    counter_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             afull_o,
  output logic             credit_o,
  output logic             ovf_o,
  output logic             udf_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    first_q, first_d;
  logic [PW-1:0]    last_q, last_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             credit_q;
  logic             pull_ok, push_ok;
  logic [CW-1:0]    diff;

  // Wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pull is resolved first; a pull frees a slot for a same-cycle push.
  assign pull_ok = pull_i & ~empty_q;
  assign push_ok = push_i & (~full_q | pull_ok);
  assign ovf_o   = push_i & full_q & ~pull_ok;
  assign udf_o   = pull_i & empty_q;

  always_comb begin
    first_d = first_q;
    last_d  = last_q;
    full_d  = full_q;
    empty_d = empty_q;
    if (pull_ok) first_d = inc(first_q);
    if (push_ok) last_d = inc(last_q);
    if (push_ok & ~pull_ok) begin
      empty_d = 1'b0;
      full_d  = (inc(last_q) == first_q);
    end else if (pull_ok & ~push_ok) begin
      full_d  = 1'b0;
      empty_d = (inc(first_q) == last_q);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      first_q  <= '0;
      last_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      credit_q <= 1'b0;
    end else begin
      first_q  <= first_d;
      last_q   <= last_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      credit_q <= pull_ok;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[last_q] <= tail_i;
  end

  always_comb begin
    diff = CW'(last_q) - CW'(first_q);
    if (last_q < first_q) diff = diff + CW'(DEPTH);
    counter_o = full_q ? CW'(DEPTH) : diff;
  end

  assign head_o   = mem_q[first_q];
  assign empty_o  = empty_q;
  assign full_o   = full_q;
  assign afull_o  = (counter_o >= CW'(AF_LEVEL));
  assign credit_o = credit_q;

endmodule

// File: rtl/vc_fifo_buffer.sv
// Router input buffer: NUM_VC FIFOs on one write port, sticky errors.
// Ports: push/push_vc/tail/pull in; head/counter/flags/credit/errors out.
module vc_fifo_buffer
  import vc_fifo_buffer_pkg::*;
#(
  parameter int WIDTH    = TAM_FLIT,
  parameter int DEPTH    = TAM_BUFFER,
  parameter int NUM_VC   = TAM_VC,
  parameter int AF_LEVEL = DEPTH - 1,
  localparam int VCW     = vc_width(NUM_VC),
  localparam int CW      = cnt_width(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic [VCW-1:0]          push_vc,
  input  logic [WIDTH-1:0]        tail,
  input  logic [NUM_VC-1:0]       pull,
  output logic [NUM_VC*WIDTH-1:0] head,
  output logic [NUM_VC*CW-1:0]    counter,
  output logic [NUM_VC-1:0]       empty,
  output logic [NUM_VC-1:0]       full,
  output logic [NUM_VC-1:0]       almost_full,
  output logic [NUM_VC-1:0]       credit,
  output logic                    overflow,
  output logic                    underflow
);

  logic [NUM_VC-1:0] ovf_s, udf_s;
  logic              bad_vc;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  assign bad_vc = push & (32'(push_vc) >= NUM_VC);

  for (genvar v = 0; v < NUM_VC; v++) begin : g_lane
    vc_fifo_lane #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL),
      .CW       (CW)
    ) u_lane (
      .clock     (clock),
      .reset     (reset),
      .push_i    (push & (push_vc == VCW'(v))),
      .pull_i    (pull[v]),
      .tail_i    (tail),
      .head_o    (head[v*WIDTH +: WIDTH]),
      .counter_o (counter[v*CW +: CW]),
      .empty_o   (empty[v]),
      .full_o    (full[v]),
      .afull_o   (almost_full[v]),
      .credit_o  (credit[v]),
      .ovf_o     (ovf_s[v]),
      .udf_o     (udf_s[v])
    );
  end

  assign ovf_d = ovf_q | (|ovf_s) | bad_vc;
  assign udf_d = udf_q | (|udf_s);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_vc_fifo_buffer.sv
// Scoreboarded bench for vc_fifo_buffer (WIDTH=16, DEPTH=4, NUM_VC=2).
// Directed stimulus; a negedge monitor checks every successful pull.
module tb_vc_fifo_buffer;

  logic        clock;
  logic        reset;
  logic        push;
  logic [0:0]  push_vc;
  logic [15:0] tail;
  logic [1:0]  pull;
  logic [31:0] head;
  logic [5:0]  counter;
  logic [1:0]  empty, full, almost_full, credit;
  logic        overflow, underflow;

  int total = 0;
  int bad   = 0;

  logic [15:0] q0 [$];
  logic [15:0] q1 [$];

  vc_fifo_buffer #(
    .WIDTH    (16),
    .DEPTH    (4),
    .NUM_VC   (2),
    .AF_LEVEL (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .push        (push),
    .push_vc     (push_vc),
    .tail        (tail),
    .pull        (pull),
    .head        (head),
    .counter     (counter),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .credit      (credit),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // A pull on a non-empty channel presents the oldest flit.
  always @(negedge clock) begin
    if (reset) begin
      if (pull[0] && !empty[0]) begin
        if (q0.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_head0: got %h want none", head[15:0]);
        end else begin
          chk("sb_head0", {16'h0, head[15:0]}, {16'h0, q0.pop_front()});
        end
      end
      if (pull[1] && !empty[1]) begin
        if (q1.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_head1: got %h want none", head[31:16]);
        end else begin
          chk("sb_head1", {16'h0, head[31:16]}, {16'h0, q1.pop_front()});
        end
      end
    end
  end

  initial begin
    reset   = 1'b0;
    push    = 1'b0;
    push_vc = 1'b0;
    tail    = 16'h0;
    pull    = 2'b00;
    #12;
    chk("rst_counter", {26'h0, counter}, 32'h0);
    chk("rst_empty", {30'h0, empty}, 32'h3);
    chk("rst_full", {30'h0, full}, 32'h0);
    chk("rst_af", {30'h0, almost_full}, 32'h0);
    chk("rst_credit", {30'h0, credit}, 32'h0);
    chk("rst_ovf", {31'h0, overflow}, 32'h0);
    chk("rst_udf", {31'h0, underflow}, 32'h0);
    #1 reset = 1'b1;
    tick();

    // Fill VC0.
    for (int i = 0; i < 4; i++) begin
      push    = 1'b1;
      push_vc = 1'b0;
      tail    = 16'(16'hA001 + i);
      q0.push_back(tail);
      tick();
      chk("fill_cnt0", {29'h0, counter[2:0]}, 32'(i + 1));
      chk("fill_af0", {31'h0, almost_full[0]}, {31'h0, i >= 2});
      chk("fill_full0", {31'h0, full[0]}, {31'h0, i == 3});
    end
    push = 1'b0;
    chk("vc1_cnt", {29'h0, counter[5:3]}, 32'h0);
    chk("vc1_empty", {31'h0, empty[1]}, 32'h1);

    // Full channel: push and pull together.
    push = 1'b1;
    tail = 16'hA005;
    pull = 2'b01;
    q0.push_back(tail);
    tick();
    push = 1'b0;
    pull = 2'b00;
    chk("pp_head0", {16'h0, head[15:0]}, 32'hA002);
    chk("pp_cnt0", {29'h0, counter[2:0]}, 32'h4);
    chk("pp_full0", {31'h0, full[0]}, 32'h1);
    chk("pp_ovf", {31'h0, overflow}, 32'h0);
    chk("pp_credit", {30'h0, credit}, 32'h1);

    // Full channel: push alone overflows, contents unchanged.
    push = 1'b1;
    tail = 16'hBEEF;
    tick();
    push = 1'b0;
    chk("ov_flag", {31'h0, overflow}, 32'h1);
    chk("ov_cnt0", {29'h0, counter[2:0]}, 32'h4);
    chk("ov_head0", {16'h0, head[15:0]}, 32'hA002);
    chk("ov_credit", {30'h0, credit}, 32'h0);
    tick();
    chk("ov_sticky", {31'h0, overflow}, 32'h1);

    // Drain VC0: monitor expects A002..A005.
    pull = 2'b01;
    repeat (4) tick();
    pull = 2'b00;
    chk("dr_empty0", {31'h0, empty[0]}, 32'h1);
    chk("dr_cnt0", {29'h0, counter[2:0]}, 32'h0);
    chk("dr_ovf", {31'h0, overflow}, 32'h1);

    // Empty VC1: pull ignored, push lands.
    push    = 1'b1;
    push_vc = 1'b1;
    tail    = 16'h1234;
    pull    = 2'b10;
    q1.push_back(tail);
    tick();
    push = 1'b0;
    pull = 2'b00;
    chk("ep_cnt1", {29'h0, counter[5:3]}, 32'h1);
    chk("ep_head1", {16'h0, head[31:16]}, 32'h1234);
    chk("ep_udf", {31'h0, underflow}, 32'h1);
    chk("ep_credit", {30'h0, credit}, 32'h0);
    pull = 2'b10;
    tick();
    pull = 2'b00;
    chk("ep_empty1", {31'h0, empty[1]}, 32'h1);
    chk("ep_credit1", {30'h0, credit}, 32'h2);

    // Wrap: steady push+pull with two flits resident.
    push    = 1'b1;
    push_vc = 1'b0;
    tail    = 16'hB000;
    q0.push_back(tail);
    tick();
    tail = 16'hB001;
    q0.push_back(tail);
    tick();
    chk("wr_cnt0_pre", {29'h0, counter[2:0]}, 32'h2);
    for (int i = 0; i < 10; i++) begin
      tail = 16'(16'hB002 + i);
      q0.push_back(tail);
      pull = 2'b01;
      tick();
      chk("wr_cnt0", {29'h0, counter[2:0]}, 32'h2);
      chk("wr_credit0", {31'h0, credit[0]}, 32'h1);
    end
    push = 1'b0;
    pull = 2'b00;

    // Reset in the middle of a burst, between edges.
    push = 1'b1;
    tail = 16'hC000;
    tick();
    tail = 16'hC001;
    tick();
    #2 reset = 1'b0;
    #1;
    chk("mr_counter", {26'h0, counter}, 32'h0);
    chk("mr_empty", {30'h0, empty}, 32'h3);
    chk("mr_full", {30'h0, full}, 32'h0);
    chk("mr_af", {30'h0, almost_full}, 32'h0);
    chk("mr_credit", {30'h0, credit}, 32'h0);
    chk("mr_ovf", {31'h0, overflow}, 32'h0);
    chk("mr_udf", {31'h0, underflow}, 32'h0);
    push = 1'b0;
    q0.delete();
    q1.delete();
    #3 reset = 1'b1;
    push = 1'b1;
    tail = 16'hD000;
    q0.push_back(tail);
    tick();
    push = 1'b0;
    chk("ar_head0", {16'h0, head[15:0]}, 32'hD000);
    chk("ar_cnt0", {29'h0, counter[2:0]}, 32'h1);
    chk("ar_empty0", {31'h0, empty[0]}, 32'h0);
    pull = 2'b01;
    tick();
    pull = 2'b00;
    chk("ar_drained", {31'h0, empty[0]}, 32'h1);
    chk("sb_left", 32'(q0.size() + q1.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
